// File: rtl/imm_encoder.sv
// imm_encoder
//
// Packs an immediate value into the RISC-V immediate fields of a 32-bit
// template instruction (the inverse of the decode-side immediate select).
// A "load immediate" (LI) select builds a LUI+ADDI pair that loads
// ID + i_thread_index into register rd. One registered output stage with
// valid/ready handshakes on both sides.
//
// Ports:
//   clk            : clock, rising edge
//   resetn         : asynchronous active-low reset
//   i_valid/o_ready: request handshake
//   i_imm_sel      : 0 U, 1 I, 2 S, 3 B, 4 J, 5 LI, 6/7 reserved
//   i_imm          : immediate (ignored for LI)
//   i_template     : instruction template (ignored for LI)
//   i_rd           : destination register for LI
//   i_thread_index : thread index for LI
//   o_valid/i_ready: output handshake
//   o_instruction  : encoded instruction word
//   o_last         : last word of the current request
//   o_range_err    : immediate out of range or misaligned
//
// Optional feature macro: IMM_ENC_COMPRESS_LI_EN
//   When defined, LI emits a single word whenever the value fits in one
//   ADDI (from x0) or one LUI.

module imm_encoder #(
  parameter logic [31:0] ID          = 32'h0,
  parameter int          NUM_THREADS = 16,
  localparam int         TIW         = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [2:0]     i_imm_sel,
  input  logic [31:0]    i_imm,
  input  logic [31:0]    i_template,
  input  logic [4:0]     i_rd,
  input  logic [TIW-1:0] i_thread_index,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [31:0]    o_instruction,
  output logic           o_last,
  output logic           o_range_err
);

  typedef enum logic {
    S_IDLE,
    S_LI_LO
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [31:0] pend_q, pend_d;

  logic        accept;
  logic [31:0] li_v;
  logic [19:0] li_hi;
  logic [31:0] li_lui;
  logic [31:0] li_addi;

  logic [31:0] enc_word;
  logic        enc_last;
  logic        enc_err;
  logic        enc_two;
  logic [31:0] enc_pend;

  assign o_ready = (!valid_q || i_ready) && (state_q == S_IDLE);
  assign accept  = i_valid && o_ready;

  // The ADDI sign-extends its 12-bit operand, so the upper part is rounded
  // up whenever bit 11 of the value is set.
  assign li_v    = ID + {{(32-TIW){1'b0}}, i_thread_index};
  assign li_hi   = li_v[31:12] + {19'b0, li_v[11]};
  assign li_lui  = {li_hi, i_rd, OP_LUI};
  assign li_addi = {li_v[11:0], i_rd, 3'b000, i_rd, OP_OP_IMM};

  // Field packing and range checks for the request being presented.
  always_comb begin
    enc_word = i_template;
    enc_last = 1'b1;
    enc_err  = 1'b0;
    enc_two  = 1'b0;
    enc_pend = 32'h0;
    case (i_imm_sel)
      3'd0: begin
        enc_word = {i_imm[31:12], i_template[11:0]};
        enc_err  = |i_imm[11:0];
      end
      3'd1: begin
        enc_word = {i_imm[11:0], i_template[19:0]};
        enc_err  = !((&i_imm[31:11]) || !(|i_imm[31:11]));
      end
      3'd2: begin
        enc_word = {i_imm[11:5], i_template[24:12], i_imm[4:0], i_template[6:0]};
        enc_err  = !((&i_imm[31:11]) || !(|i_imm[31:11]));
      end
      3'd3: begin
        enc_word = {i_imm[12], i_imm[10:5], i_template[24:12], i_imm[4:1],
                    i_imm[11], i_template[6:0]};
        enc_err  = !((&i_imm[31:12]) || !(|i_imm[31:12])) || i_imm[0];
      end
      3'd4: begin
        enc_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                    i_template[11:0]};
        enc_err  = !((&i_imm[31:20]) || !(|i_imm[31:20])) || i_imm[0];
      end
      3'd5: begin
`ifdef IMM_ENC_COMPRESS_LI_EN
        // Values within the signed 12-bit range need only ADDI rd,x0,lo;
        // values with a zero low part need only the LUI.
        if ((&li_v[31:11]) || !(|li_v[31:11])) begin
          enc_word = {li_v[11:0], 5'd0, 3'b000, i_rd, OP_OP_IMM};
        end else if (li_v[11:0] == 12'h0) begin
          enc_word = li_lui;
        end else begin
          enc_word = li_lui;
          enc_last = 1'b0;
          enc_two  = 1'b1;
          enc_pend = li_addi;
        end
`else
        enc_word = li_lui;
        enc_last = 1'b0;
        enc_two  = 1'b1;
        enc_pend = li_addi;
`endif
      end
      default: begin
        enc_word = i_template;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Output register / LI sequencing. The pending ADDI moves into the output
  // register in the same cycle the LUI transfers, so the pair has no bubble.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    instr_d = instr_q;
    last_d  = last_q;
    err_d   = err_q;
    pend_d  = pend_q;
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
    if ((state_q == S_LI_LO) && valid_q && i_ready) begin
      valid_d = 1'b1;
      instr_d = pend_q;
      last_d  = 1'b1;
      err_d   = 1'b0;
      pend_d  = 32'h0;
      state_d = S_IDLE;
    end else if (accept) begin
      valid_d = 1'b1;
      instr_d = enc_word;
      last_d  = enc_last;
      err_d   = enc_err;
      if (enc_two) begin
        pend_d  = enc_pend;
        state_d = S_LI_LO;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_instruction = instr_q;
  assign o_last        = last_q;
  assign o_range_err   = err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder
//
// Two encoder instances: "a" with a large base ID (always a two-word LI),
// "b" with a small base ID (single-word LI when compression is enabled).
// They share all inputs except the request valid.

module tb_imm_encoder;

  localparam logic [31:0] ID_A = 32'h12345800;
  localparam logic [31:0] ID_B = 32'h00000100;

  typedef struct packed {
    logic [31:0] instr;
    logic        last;
    logic        err;
  } word_t;

  logic        clk;
  logic        resetn;
  logic        i_valid;
  logic        i_valid2;
  logic [2:0]  i_imm_sel;
  logic [31:0] i_imm;
  logic [31:0] i_template;
  logic [4:0]  i_rd;
  logic [3:0]  i_thread_index;
  logic        i_ready;

  logic        o_ready_a, o_valid_a, o_last_a, o_err_a;
  logic [31:0] o_instr_a;
  logic        o_ready_b, o_valid_b, o_last_b, o_err_b;
  logic [31:0] o_instr_b;

  logic        which;
  logic        obs_ready, obs_valid, obs_last, obs_err;
  logic [31:0] obs_instr;

  int    n_checks;
  int    n_fail;
  word_t exp_q[$];

  imm_encoder #(.ID(ID_A), .NUM_THREADS(16)) dut_a (
    .clk(clk), .resetn(resetn), .i_valid(i_valid), .o_ready(o_ready_a),
    .i_imm_sel(i_imm_sel), .i_imm(i_imm), .i_template(i_template),
    .i_rd(i_rd), .i_thread_index(i_thread_index), .o_valid(o_valid_a),
    .i_ready(i_ready), .o_instruction(o_instr_a), .o_last(o_last_a),
    .o_range_err(o_err_a)
  );

  imm_encoder #(.ID(ID_B), .NUM_THREADS(16)) dut_b (
    .clk(clk), .resetn(resetn), .i_valid(i_valid2), .o_ready(o_ready_b),
    .i_imm_sel(i_imm_sel), .i_imm(i_imm), .i_template(i_template),
    .i_rd(i_rd), .i_thread_index(i_thread_index), .o_valid(o_valid_b),
    .i_ready(i_ready), .o_instruction(o_instr_b), .o_last(o_last_b),
    .o_range_err(o_err_b)
  );

  assign obs_ready = which ? o_ready_b : o_ready_a;
  assign obs_valid = which ? o_valid_b : o_valid_a;
  assign obs_instr = which ? o_instr_b : o_instr_a;
  assign obs_last  = which ? o_last_b  : o_last_a;
  assign obs_err   = which ? o_err_b   : o_err_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected output words for one request, computed from
  // the instruction-format field positions with plain arithmetic.
  function automatic void model(input logic [2:0] sel, input logic [31:0] imm,
                                input logic [31:0] tmpl, input logic [4:0] rd,
                                input logic [31:0] v);
    longint      s;
    logic [31:0] lo, hi, lui, addi, r;
    word_t       w;
    s = longint'($signed(imm));
    r = 32'(rd);
    w.instr = tmpl;
    w.last  = 1'b1;
    w.err   = 1'b0;
    case (sel)
      3'd0: begin
        w.instr = (imm & 32'hFFFFF000) | (tmpl & 32'h00000FFF);
        w.err   = (imm % 4096) != 0;
        exp_q.push_back(w);
      end
      3'd1: begin
        w.instr = (tmpl & 32'h000FFFFF) | (imm << 20);
        w.err   = (s < -2048) || (s > 2047);
        exp_q.push_back(w);
      end
      3'd2: begin
        w.instr = (tmpl & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25)
                | ((imm & 32'h1F) << 7);
        w.err   = (s < -2048) || (s > 2047);
        exp_q.push_back(w);
      end
      3'd3: begin
        w.instr = (tmpl & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31)
                | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                | (((imm >> 11) & 32'h1) << 7);
        w.err   = (s < -4096) || (s > 4094) || ((imm % 2) != 0);
        exp_q.push_back(w);
      end
      3'd4: begin
        w.instr = (tmpl & 32'h00000FFF) | (((imm >> 20) & 32'h1) << 31)
                | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                | (((imm >> 12) & 32'hFF) << 12);
        w.err   = (s < -1048576) || (s > 1048574) || ((imm % 2) != 0);
        exp_q.push_back(w);
      end
      3'd5: begin
        lo   = v % 4096;
        hi   = (v + 32'h800) >> 12;
        lui  = (hi << 12) | (r << 7) | 32'h37;
        addi = (lo << 20) | (r << 15) | (r << 7) | 32'h13;
`ifdef IMM_ENC_COMPRESS_LI_EN
        if (longint'($signed(v)) >= -2048 && longint'($signed(v)) <= 2047) begin
          w.instr = (lo << 20) | (r << 7) | 32'h13;
          exp_q.push_back(w);
        end else if (lo == 0) begin
          w.instr = lui;
          exp_q.push_back(w);
        end else begin
          w.instr = lui;  w.last = 1'b0; exp_q.push_back(w);
          w.instr = addi; w.last = 1'b1; exp_q.push_back(w);
        end
`else
        w.instr = lui;  w.last = 1'b0; exp_q.push_back(w);
        w.instr = addi; w.last = 1'b1; exp_q.push_back(w);
`endif
      end
      default: begin
        w.err = 1'b1;
        exp_q.push_back(w);
      end
    endcase
  endfunction

  function automatic logic [31:0] gen_imm();
    logic [31:0] b[13];
    b = '{32'hFFFFF7FF, 32'hFFFFF800, 32'd2047, 32'd2048, 32'hFFFFF000,
          32'd4094, 32'd4095, 32'hFFFFEFFF, 32'hFFF00000, 32'd1048574,
          32'd1048575, 32'd0, 32'h12345000};
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 8191)) - 32'd4096;
      1:       return b[$urandom_range(0, 12)];
      2:       return $urandom;
      default: return 32'($urandom_range(0, 4194303)) - 32'h200000;
    endcase
  endfunction

  // One request on instance "a" (use_b=0) or "b" (use_b=1). Each output word
  // may be stalled for some cycles; stall < 0 means exactly -stall cycles.
  task automatic do_request(input bit use_b, input logic [2:0] sel,
                            input logic [31:0] imm, input logic [31:0] tmpl,
                            input logic [4:0] rd, input logic [3:0] thr,
                            input int stall, input string name);
    word_t w;
    int    waited;
    int    nst;
    exp_q.delete();
    model(sel, imm, tmpl, rd, (use_b ? ID_B : ID_A) + 32'(thr));
    which          = use_b;
    i_imm_sel      = sel;
    i_imm          = imm;
    i_template     = tmpl;
    i_rd           = rd;
    i_thread_index = thr;
    i_ready        = 1'b1;
    #1;
    waited = 0;
    while (!obs_ready && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    n_checks++;
    if (!obs_ready) begin
      n_fail++;
      $display("[TB] FAIL %s accept_timeout: o_ready=%0b required 1", name, obs_ready);
      return;
    end
    if (use_b) i_valid2 = 1'b1; else i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid  = 1'b0;
    i_valid2 = 1'b0;
    while (exp_q.size() > 0) begin
      w   = exp_q.pop_front();
      nst = (stall < 0) ? -stall : ((stall > 0) ? $urandom_range(0, stall) : 0);
      repeat (nst) begin
        i_ready = 1'b0;
        #1;
        n_checks++;
        if (obs_valid !== 1'b1 || obs_instr !== w.instr || obs_last !== w.last ||
            obs_err !== w.err || obs_ready !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL %s stall_hold: got v=%0b i=%08h l=%0b e=%0b r=%0b required v=1 i=%08h l=%0b e=%0b r=0",
                   name, obs_valid, obs_instr, obs_last, obs_err, obs_ready,
                   w.instr, w.last, w.err);
        end
        @(negedge clk);
      end
      i_ready = 1'b1;
      #1;
      n_checks++;
      if (obs_valid !== 1'b1 || obs_instr !== w.instr || obs_last !== w.last ||
          obs_err !== w.err || obs_ready !== w.last) begin
        n_fail++;
        $display("[TB] FAIL %s word: got v=%0b i=%08h l=%0b e=%0b r=%0b required v=1 i=%08h l=%0b e=%0b r=%0b",
                 name, obs_valid, obs_instr, obs_last, obs_err, obs_ready,
                 w.instr, w.last, w.err, w.last);
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (obs_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s drain: o_valid=%0b required 0", name, obs_valid);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    n_checks++;
    if (o_valid_a !== 1'b0 || o_instr_a !== 32'h0 || o_last_a !== 1'b0 ||
        o_err_a !== 1'b0 || o_ready_a !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got v=%0b i=%08h l=%0b e=%0b r=%0b required 0 00000000 0 0 1",
               o_valid_a, o_instr_a, o_last_a, o_err_a, o_ready_a);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_request(0, 3'd1, 32'hFFFFFFFF, 32'h00000013, 5'd0, 4'd0, 0, "i_minus1");
    do_request(0, 3'd1, 32'd2048,     32'h00000013, 5'd0, 4'd0, 0, "i_2048");
    do_request(0, 3'd3, 32'hFFFFFFFC, 32'h00000063, 5'd0, 4'd0, 0, "b_minus4");
    do_request(0, 3'd3, 32'd3,        32'h00000063, 5'd0, 4'd0, 0, "b_odd");
    do_request(0, 3'd0, 32'hABCDE000, 32'h00000537, 5'd0, 4'd0, 1, "u_aligned");
    do_request(0, 3'd4, 32'd1048576,  32'h0000006F, 5'd0, 4'd0, 0, "j_over");
    do_request(0, 3'd6, 32'h0,        32'hDEADBEEF, 5'd0, 4'd0, 0, "reserved");
  endtask

  task automatic test_backpressure();
    do_request(0, 3'd2, 32'd8, 32'h00002023, 5'd0, 4'd0, -5, "s_backpressure");
  endtask

  task automatic test_li();
    do_request(0, 3'd5, 32'h0, 32'h0, 5'd5, 4'd0, 0, "li_a_t0");
    do_request(0, 3'd5, 32'h0, 32'h0, 5'd7, 4'd9, 2, "li_a_t9_stall");
    do_request(1, 3'd5, 32'h0, 32'h0, 5'd1, 4'd3, 0, "li_b_t3");
    do_request(1, 3'd5, 32'h0, 32'h0, 5'd2, 4'd15, 1, "li_b_t15");
  endtask

  task automatic test_back_to_back();
    word_t w;
    logic  have;
    exp_q.delete();
    which   = 1'b0;
    i_ready = 1'b1;
    have    = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_imm_sel  = 3'($urandom_range(0, 4));
      i_imm      = gen_imm();
      i_template = $urandom;
      i_valid    = 1'b1;
      #1;
      n_checks++;
      if (o_ready_a !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL b2b_ready: o_ready=%0b required 1", o_ready_a);
      end
      if (have) begin
        w = exp_q.pop_front();
        n_checks++;
        if (o_valid_a !== 1'b1 || o_instr_a !== w.instr || o_last_a !== w.last ||
            o_err_a !== w.err) begin
          n_fail++;
          $display("[TB] FAIL b2b_word: got v=%0b i=%08h l=%0b e=%0b required v=1 i=%08h l=%0b e=%0b",
                   o_valid_a, o_instr_a, o_last_a, o_err_a, w.instr, w.last, w.err);
        end
      end
      model(i_imm_sel, i_imm, i_template, i_rd, ID_A);
      have = 1'b1;
      @(negedge clk);
    end
    i_valid = 1'b0;
    #1;
    w = exp_q.pop_front();
    n_checks++;
    if (o_valid_a !== 1'b1 || o_instr_a !== w.instr || o_err_a !== w.err) begin
      n_fail++;
      $display("[TB] FAIL b2b_tail: got v=%0b i=%08h e=%0b required v=1 i=%08h e=%0b",
               o_valid_a, o_instr_a, o_err_a, w.instr, w.err);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (o_valid_a !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_drain: o_valid=%0b required 0", o_valid_a);
    end
  endtask

  task automatic test_reset_mid_li();
    exp_q.delete();
    model(3'd5, 32'h0, 32'h0, 5'd5, ID_A);
    which          = 1'b0;
    i_imm_sel      = 3'd5;
    i_rd           = 5'd5;
    i_thread_index = 4'd0;
    i_ready        = 1'b0;
    i_valid        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    n_checks++;
    if (o_valid_a !== 1'b1 || o_instr_a !== exp_q[0].instr) begin
      n_fail++;
      $display("[TB] FAIL rst_li_lui: got v=%0b i=%08h required v=1 i=%08h",
               o_valid_a, o_instr_a, exp_q[0].instr);
    end
    #1 resetn = 1'b0;
    #1;
    n_checks++;
    if (o_valid_a !== 1'b0 || o_ready_a !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_li_async: got v=%0b r=%0b required v=0 r=1",
               o_valid_a, o_ready_a);
    end
    @(negedge clk);
    resetn  = 1'b1;
    i_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (o_valid_a !== 1'b0 || o_ready_a !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL rst_li_after: got v=%0b r=%0b required v=0 r=1",
                 o_valid_a, o_ready_a);
      end
    end
    @(negedge clk);
    do_request(0, 3'd1, 32'd100, 32'h00000013, 5'd0, 4'd0, 0, "rst_li_recover");
  endtask

  task automatic test_random();
    logic [2:0] sel;
    for (int k = 0; k < 60; k++) begin
      sel = 3'($urandom_range(0, 7));
      do_request(1'($urandom_range(0, 1)), sel, gen_imm(), $urandom,
                 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 2, "random");
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    which          = 1'b0;
    resetn         = 1'b1;
    i_valid        = 1'b0;
    i_valid2       = 1'b0;
    i_imm_sel      = 3'd0;
    i_imm          = 32'h0;
    i_template     = 32'h0;
    i_rd           = 5'd0;
    i_thread_index = 4'd0;
    i_ready        = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_li();
    test_back_to_back();
    test_reset_mid_li();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
